// File: rtl/ask2_pio_bidir_irq.sv
// Bidirectional parallel I/O port on an Avalon-MM slave: per-bit direction, synchronised inputs,
// edge capture with maskable registered IRQ, and atomic set/clear of the output register.
module ask2_pio_bidir_irq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    localparam logic [2:0] WarmMax = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] data_dir_q, data_dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [2:0]       warm_q, warm_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise, fall, edge_det, cap_clr;

    assign wr_en   = chipselect & ~write_n;
    assign wdata   = writedata[WIDTH-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
        end
    endgenerate

    always_comb begin
        data_out_d = data_out_q;
        data_dir_d = data_dir_q;
        irq_mask_d = irq_mask_q;
        cap_clr    = '0;
        if (wr_en) begin
            case (address)
                3'd0:    data_out_d = wdata;
                3'd1:    data_dir_d = wdata;
                3'd2:    irq_mask_d = wdata;
                3'd3:    cap_clr    = wdata;
                3'd4:    data_out_d = data_out_q | wdata;
                3'd5:    data_out_d = data_out_q & ~wdata;
                default: ;
            endcase
        end

        sync_d = {sync_q[SYNC_STAGES-2:0], bidir_port};
        prev_d = sync_in;
        warm_d = (warm_q == WarmMax) ? warm_q : warm_q + 3'd1;

        rise = sync_in & ~prev_q;
        fall = ~sync_in & prev_q;
        if (EDGE_TYPE == 0)      edge_det = rise;
        else if (EDGE_TYPE == 1) edge_det = fall;
        else                     edge_det = rise | fall;
        // Suppress edges until the synchroniser and prev flop hold real pin values.
        if (warm_q != WarmMax) edge_det = '0;

        // A new edge takes priority over a simultaneous write-1-to-clear.
        edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;

        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = sync_in;
            3'd1:    readdata_d[WIDTH-1:0] = data_dir_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase

        irq_d = |(edge_capture_q & irq_mask_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q     <= RESET_OUT[WIDTH-1:0];
            data_dir_q     <= RESET_DIR[WIDTH-1:0];
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            prev_q         <= '0;
            sync_q         <= '0;
            warm_q         <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            data_out_q     <= data_out_d;
            data_dir_q     <= data_dir_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            prev_q         <= prev_d;
            sync_q         <= sync_d;
            warm_q         <= warm_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_ask2_pio_bidir_irq.sv
// Directed bench for ask2_pio_bidir_irq: instance A (rising edges, reset-driven pins) and
// instance B (any edge, pins held high through reset).
module tb_ask2_pio_bidir_irq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, cs_a, cs_b, write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b, v;
    logic        irq_a, irq_b;
    wire  [7:0]  pins_a, pins_b;
    logic [7:0]  en_a, val_a, en_b, val_b;
    int          errors = 0;
    int          checks = 0;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign pins_a[i] = en_a[i] ? val_a[i] : 1'bz;
        assign pins_b[i] = en_b[i] ? val_b[i] : 1'bz;
    end

    ask2_pio_bidir_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_OUT(32'hA5), .RESET_DIR(32'hFF)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a),
        .bidir_port(pins_a)
    );

    ask2_pio_bidir_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_OUT(32'h0), .RESET_DIR(32'h0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .irq(irq_b),
        .bidir_port(pins_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write commits on the next rising edge.
    task automatic wr(input bit sel_b, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_a      = ~sel_b;
        cs_b      = sel_b;
        @(negedge clk);
        write_n   = 1'b1;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
    endtask

    task automatic rd(input bit sel_b, input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = sel_b ? rd_b : rd_a;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0;
        en_a = 8'h00; val_a = 8'h00; en_b = 8'hFF; val_b = 8'hFF;
        cyc(3);
        chk("reset_pins_a", {24'h0, pins_a}, 32'hA5);
        chk("reset_rd_a", rd_a, 32'h0);
        chk("reset_irq_a", {31'h0, irq_a}, 32'h0);
        chk("reset_rd_b", rd_b, 32'h0);
        reset_n = 1'b1;
        cyc(5);
        rd(0, 3'd3, v); chk("a_edgecap_warm", v, 32'h0);
        rd(1, 3'd3, v); chk("b_edgecap_warm", v, 32'h0);

        // Split direction: low nibble driven by DUT, high nibble by the bench.
        wr(0, 3'd1, 32'h0F);
        en_a = 8'hF0; val_a = 8'h90;
        wr(0, 3'd0, 32'h3C);
        chk("split_pins", {24'h0, pins_a}, 32'h9C);
        cyc(3);
        rd(0, 3'd0, v); chk("split_data_read", v, 32'h9C);
        rd(0, 3'd1, v); chk("dir_read", v, 32'h0F);

        // Atomic set/clear, back to back.
        en_a = 8'h00;
        wr(0, 3'd0, 32'h0);
        wr(0, 3'd1, 32'hFF);
        cyc(1);
        wr(0, 3'd4, 32'h81);
        chk("outset_pins", {24'h0, pins_a}, 32'h81);
        wr(0, 3'd5, 32'h01);
        chk("outclr_pins", {24'h0, pins_a}, 32'h80);
        rd(0, 3'd4, v); chk("outset_read", v, 32'h0);
        rd(0, 3'd5, v); chk("outclr_read", v, 32'h0);
        wr(0, 3'd6, 32'hFF);
        cyc(2);
        rd(0, 3'd0, v); chk("data_after_set_clr", v, 32'h80);
        rd(0, 3'd7, v); chk("addr7_read", v, 32'h0);

        // Rising edge on pin2 with mask bit2; latency relative to first sampling edge k.
        wr(0, 3'd1, 32'h00);
        en_a = 8'hFF; val_a = 8'h00;
        cyc(4);
        wr(0, 3'd3, 32'hFF);
        wr(0, 3'd2, 32'hFFFF_FF04);
        rd(0, 3'd2, v); chk("mask_read_upper_zero", v, 32'h04);
        chk("irq_idle", {31'h0, irq_a}, 32'h0);
        address = 3'd3;
        val_a   = 8'h04;
        cyc(3);
        chk("irq_at_k2", {31'h0, irq_a}, 32'h0);
        chk("cap_before_k2", rd_a, 32'h0);
        cyc(1);
        chk("irq_at_k3", {31'h0, irq_a}, 32'h1);
        chk("cap_after_k2", rd_a, 32'h04);
        wr(0, 3'd3, 32'h04);
        chk("irq_lags_clear", {31'h0, irq_a}, 32'h1);
        cyc(1);
        chk("irq_cleared", {31'h0, irq_a}, 32'h0);
        val_a = 8'h06;
        cyc(4);
        rd(0, 3'd3, v); chk("cap_bit1_unmasked", v, 32'h02);
        chk("irq_bit1_unmasked", {31'h0, irq_a}, 32'h0);

        // Edge and write-1-clear on the same bit in the same cycle: set wins.
        wr(0, 3'd3, 32'hFF);
        val_a = 8'h02;
        cyc(4);
        val_a = 8'h06;
        cyc(4);
        chk("irq_pin2_again", {31'h0, irq_a}, 32'h1);
        val_a = 8'h02;
        cyc(4);
        val_a = 8'h06;
        cyc(2);
        wr(0, 3'd3, 32'h04);
        cyc(1);
        chk("irq_race", {31'h0, irq_a}, 32'h1);
        rd(0, 3'd3, v); chk("cap_race", v, 32'h04);

        // Instance B: any-edge capture of a falling pin0, then mid-operation reset.
        val_b = 8'hFE;
        cyc(4);
        rd(1, 3'd3, v); chk("b_fall_cap", v, 32'h01);
        wr(1, 3'd2, 32'h01);
        cyc(2);
        chk("b_irq", {31'h0, irq_b}, 32'h1);
        en_a = 8'h00;
        reset_n = 1'b0;
        cyc(1);
        chk("midrst_irq_b", {31'h0, irq_b}, 32'h0);
        chk("midrst_rd_b", rd_b, 32'h0);
        chk("midrst_pins_a", {24'h0, pins_a}, 32'hA5);
        reset_n = 1'b1;
        cyc(5);
        rd(1, 3'd3, v); chk("b_cap_rewarm", v, 32'h0);
        rd(1, 3'd2, v); chk("b_mask_reset", v, 32'h0);
        chk("b_irq_after_rst", {31'h0, irq_b}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
